// File: rtl/shift_seq_ctrl.sv
// Serial shift-chain sequencer: accepts a parallel word over valid/ready and
// emits it one bit per DIV clocks, with per-bit strobes and a done pulse.
module shift_seq_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DIV       = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         abort,
   output logic                         ser_out,
   output logic                         ser_en,
   output logic                         bit_strobe,
   output logic                         done,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sreg;
   logic [PW-1:0]    pre;
   logic             strobe;
   logic             head;

   assign strobe = (state == SHIFT) && (pre == PRE_LAST);
   assign head   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Abort takes priority over the final strobe, so an aborted word never reaches DONE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = SHIFT;
         SHIFT: begin
            if (abort)                               state_nx = IDLE;
            else if (strobe && (bit_cnt == LAST_BIT)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state == IDLE);
      ser_en     = (state == SHIFT);
      ser_out    = (state == SHIFT) ? head : 1'b0;
      bit_strobe = strobe;
      done       = (state == DONE);
   end

   // Shift register fills with zeros from the tail; bit_cnt reaches WIDTH only in DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sreg    <= '0;
         pre     <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg    <= in_data;
                  pre     <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (abort) begin
                  sreg    <= '0;
                  pre     <= '0;
                  bit_cnt <= '0;
               end else if (strobe) begin
                  if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
                  else           sreg <= {1'b0, sreg[WIDTH-1:1]};
                  pre     <= '0;
                  bit_cnt <= bit_cnt + CW'(1);
               end else begin
                  pre <= pre + PW'(1);
               end
            end
            DONE: begin
               pre     <= '0;
               bit_cnt <= '0;
            end
            default: begin
               sreg    <= '0;
               pre     <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule
